write_prog_fetch: RTL and testbench
===================================

# write_prog_fetch

Instruction-memory front end for the disc write engine. Holds the 8-bit write-program RAM, lets the host load it through an auto-incrementing pointer, and presents the current instruction byte on `mdat`. A two-entry prefetch buffer keeps `mdat` valid on the same clock-enable edge on which the engine both asserts its `maddr_inc` and samples the next instruction. It sits directly upstream of the write engine and consumes its `maddr_inc`/`running` outputs.

## Interface
- `AW`, 16, RAM address width; depth is 2^AW bytes.
- `clock`  in  1  master clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clken`  in  1  engine clock enable; the same signal that drives the write engine.
- `hst_addr_ld`  in  1  load host pointer from `hst_addr_in`.
- `hst_addr_in`  in  AW  host pointer load value.
- `hst_wr`  in  1  write `hst_wdata` to RAM[`hst_ptr`], then post-increment.
- `hst_wdata`  in  8  host write data.
- `hst_ptr`  out  AW  current host pointer.
- `eng_rewind`  in  1  reset engine pointer to 0 and refill the prefetch buffer.
- `eng_running`  in  1  engine `running` output.
- `maddr_inc`  in  1  engine memory-address-increment output (level, registered on `clken`).
- `mdat`  out  8  instruction byte to the engine.
- `eng_addr`  out  AW  address of the byte held in `cur`.
- `ready`  out  1  prefetch buffer full; host asserts engine start only when high.
- `wrapped`  out  1  sticky: engine pointer wrapped from 2^AW-1 to 0.
- `underrun`  out  1  sticky: advance requested while buffer not full.

## Operation
- RAM: simple dual-port, read-first. Host writes on the write port; the prefetcher uses a registered read port with 1-clock latency.
- Host port:
  - `hst_addr_ld` takes priority over `hst_wr` in the same cycle. The pointer loads and the write is dropped.
  - `hst_ptr` increments modulo 2^AW.
  - Host writes are accepted at any time. Bytes already in `cur` or `nxt` are not updated.
- Prefetch registers: `cur` (byte at `eng_addr`), `nxt` (byte at `eng_addr`+1), and a read address `raddr`.
- `mdat` mux: `mdat` = `maddr_inc` ? `nxt` : `cur`. This is combinational from `maddr_inc`.
- Advance event: the edge on which `clken` & `maddr_inc` & `ready`. On that edge:
  - `cur` <= `nxt`
  - `eng_addr` <= `eng_addr`+1
  - `nxt` <= RAM data for `eng_addr`+2; the read is issued so the data lands by the next edge.
  - `ready` stays 1.
- State machine:
  - IDLE: `ready`=0. Entered after reset.
  - RW0: read addr 0 issued.
  - RW1: `cur` <= data; read addr 1 issued.
  - RW2: `nxt` <= data.
  - READY: `ready`=1.
  - Transitions: IDLE/READY -> RW0 on `eng_rewind` & !`eng_running`. RW0 -> RW1 -> RW2 -> READY unconditionally.
- Rewind:
  - Ignored while `eng_running`=1.
  - Clears `wrapped` and `underrun`; sets `eng_addr`=0.
  - Wins over a simultaneous advance.
- Wrap: `eng_addr` increments modulo 2^AW. `wrapped` is set on the advance that moves 2^AW-1 to 0.
- Underrun: `clken` & `maddr_inc` while `ready`=0 sets `underrun`. No pointer change occurs.

## Timing
- Reset values: `cur`=`nxt`=8'h3F (engine STOP), `mdat`=8'h3F, `eng_addr`=0, `hst_ptr`=0, `ready`=0, `wrapped`=0, `underrun`=0, state IDLE. RAM contents are not reset.
- `eng_rewind` sampled at edge R: `ready`=1 after edge R+3. `mdat`=RAM[0] after edge R+2.
- Back-to-back advances on consecutive `clken` edges are not required. The engine's minimum spacing is 2 `clken` edges, and the fetcher sustains advances 2 clocks apart with `clken` tied high.
- `maddr_inc` held high across several non-`clken` clocks produces exactly one advance, on the `clken` edge.
- Host write to RAM[`eng_addr`+2] in the cycle that address is read returns the old byte.

## Test plan
- Reset mid-fill: deassert `reset_n` during RW1 -> all outputs return to reset values, `mdat`=8'h3F, `ready`=0.
- Host load and rewind: load bytes 02,02,3F at 0x0000 via `hst_wr`, then pulse `eng_rewind` -> `ready`=1 three clocks later, `mdat`=02, `eng_addr`=0.
- Engine sequence, `clken`=1: emulate STROBE,STROBE,STOP -> `mdat` reads 02,02,3F on the sampling edges, `eng_addr` ends at 2, `underrun`=0.
- Sparse `clken` (1 in 4): `maddr_inc` held 4 clocks -> exactly one advance per pulse, `mdat` switches to `nxt` while `maddr_inc` is high.
- Wrap with `AW`=4: program 16 bytes of 02 and advance 16 times -> `eng_addr` 15 -> 0, `wrapped`=1; the next rewind clears it.
- Guards: `eng_rewind` with `eng_running`=1 is ignored. `maddr_inc` during RW1 sets `underrun`. `hst_addr_ld`+`hst_wr` in the same cycle loads the pointer and writes nothing.

Source files
------------

// File: rtl/write_prog_fetch_if.sv
// Bus bundle between the host/write engine and the write-program fetcher.
// The host loads the program RAM through the hst_* group. The engine side
// exchanges clken/maddr_inc/running for the instruction byte on mdat.
interface write_prog_fetch_if #(
  parameter int AW = 16
);
  logic          clken;
  logic          hst_addr_ld;
  logic [AW-1:0] hst_addr_in;
  logic          hst_wr;
  logic [7:0]    hst_wdata;
  logic [AW-1:0] hst_ptr;
  logic          eng_rewind;
  logic          eng_running;
  logic          maddr_inc;
  logic [7:0]    mdat;
  logic [AW-1:0] eng_addr;
  logic          ready;
  logic          wrapped;
  logic          underrun;

  // Host/engine side: drives requests, observes fetcher state.
  modport master (
    output clken, hst_addr_ld, hst_addr_in, hst_wr, hst_wdata,
    output eng_rewind, eng_running, maddr_inc,
    input  hst_ptr, mdat, eng_addr, ready, wrapped, underrun
  );

  // Fetcher side.
  modport slave (
    input  clken, hst_addr_ld, hst_addr_in, hst_wr, hst_wdata,
    input  eng_rewind, eng_running, maddr_inc,
    output hst_ptr, mdat, eng_addr, ready, wrapped, underrun
  );
endinterface

// File: rtl/write_prog_fetch.sv
// Instruction-memory front end for the disc write engine.
// Holds the 8-bit write-program RAM with a host auto-increment load port.
// A two-entry prefetch buffer (cur/nxt) lets the engine see the next
// instruction on the same clken edge on which it raises maddr_inc.
// After an advance, nxt is refilled one clock later from a read that was
// issued during the advance cycle. This is why advances must be spaced at
// least two clocks apart.
module write_prog_fetch #(
  parameter int AW = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  write_prog_fetch_if.slave bus
);

  localparam int            DEPTH   = 1 << AW;
  localparam logic [7:0]    STOP_OP = 8'h3F;
  localparam logic [AW-1:0] ZERO_A  = {AW{1'b0}};
  localparam logic [AW-1:0] ONE_A   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] TWO_A   = {{(AW-2){1'b0}}, 2'b10};
  localparam logic [AW-1:0] LAST_A  = {AW{1'b1}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RW0   = 3'd1,
    RW1   = 3'd2,
    RW2   = 3'd3,
    READY = 3'd4
  } state_t;

  state_t        state_r;
  state_t        state_next_s;

  logic [7:0]    mem_r [DEPTH];
  logic [7:0]    rdata_r;
  logic [AW-1:0] raddr_s;

  logic [7:0]    cur_r;
  logic [7:0]    nxt_r;
  logic [AW-1:0] eng_addr_r;
  logic [AW-1:0] hst_ptr_r;
  logic          ready_r;
  logic          wrapped_r;
  logic          underrun_r;
  logic          pend_r;

  logic          host_wr_s;
  logic          inc_req_s;
  logic          rewind_go_s;
  logic          advance_s;
  logic          underrun_set_s;
  logic          wrap_s;

  // Decode this clock's host and engine requests; rewind wins over an advance.
  always_comb begin
    host_wr_s      = bus.hst_wr & ~bus.hst_addr_ld;
    inc_req_s      = bus.clken & bus.maddr_inc;
    rewind_go_s    = bus.eng_rewind & ~bus.eng_running &
                     ((state_r == IDLE) | (state_r == READY));
    advance_s      = inc_req_s & ready_r & ~rewind_go_s;
    underrun_set_s = inc_req_s & ~ready_r;
    wrap_s         = advance_s & (eng_addr_r == LAST_A);
  end

  // Fill sequencer next state: three clocks from rewind to a full buffer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (rewind_go_s) state_next_s = RW0;
        else             state_next_s = IDLE;
      end
      RW0:   state_next_s = RW1;
      RW1:   state_next_s = RW2;
      RW2:   state_next_s = READY;
      READY: begin
        if (rewind_go_s) state_next_s = RW0;
        else             state_next_s = READY;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Prefetch read address: bytes 0/1 while filling, otherwise two past cur.
  always_comb begin
    raddr_s = eng_addr_r + TWO_A;
    case (state_r)
      RW0:     raddr_s = eng_addr_r;
      RW1:     raddr_s = eng_addr_r + ONE_A;
      default: raddr_s = eng_addr_r + TWO_A;
    endcase
  end

  // Fill sequencer state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_next_s;
  end

  // Program RAM: host write port plus a registered read port that returns the pre-write byte.
  always_ff @(posedge clock) begin
    if (host_wr_s) mem_r[hst_ptr_r] <= bus.hst_wdata;
    rdata_r <= mem_r[raddr_s];
  end

  // Host pointer: a load beats a write; a write post-increments modulo depth.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hst_ptr_r <= ZERO_A;
    end else if (bus.hst_addr_ld) begin
      hst_ptr_r <= bus.hst_addr_in;
    end else if (bus.hst_wr) begin
      hst_ptr_r <= hst_ptr_r + ONE_A;
    end
  end

  // Prefetch buffer, engine pointer and sticky status flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_r      <= STOP_OP;
      nxt_r      <= STOP_OP;
      eng_addr_r <= ZERO_A;
      ready_r    <= 1'b0;
      wrapped_r  <= 1'b0;
      underrun_r <= 1'b0;
      pend_r     <= 1'b0;
    end else begin
      ready_r <= (state_next_s == READY);
      if (rewind_go_s) begin
        eng_addr_r <= ZERO_A;
        wrapped_r  <= 1'b0;
        underrun_r <= 1'b0;
        pend_r     <= 1'b0;
      end else begin
        pend_r <= advance_s;
        if (advance_s)      eng_addr_r <= eng_addr_r + ONE_A;
        if (wrap_s)         wrapped_r  <= 1'b1;
        if (underrun_set_s) underrun_r <= 1'b1;
        if (state_r == RW1)  cur_r <= rdata_r;
        else if (advance_s)  cur_r <= nxt_r;
        if ((state_r == RW2) || pend_r) nxt_r <= rdata_r;
      end
    end
  end

  assign bus.mdat     = bus.maddr_inc ? nxt_r : cur_r;
  assign bus.hst_ptr  = hst_ptr_r;
  assign bus.eng_addr = eng_addr_r;
  assign bus.ready    = ready_r;
  assign bus.wrapped  = wrapped_r;
  assign bus.underrun = underrun_r;

endmodule

// File: tb/tb_write_prog_fetch.sv
// Self-checking bench for write_prog_fetch with a 16-byte program RAM.
module tb_write_prog_fetch;

  localparam int AW = 4;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] exp_q [$];

  typedef struct {
    logic          inc;
    logic [7:0]    mdat;
    logic [AW-1:0] addr;
  } vec_t;
  vec_t vecs [5];

  write_prog_fetch_if #(.AW(AW)) bus ();

  write_prog_fetch #(.AW(AW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic host_load(input logic [AW-1:0] addr);
    bus.hst_addr_ld = 1'b1;
    bus.hst_addr_in = addr;
    tick();
    bus.hst_addr_ld = 1'b0;
  endtask

  task automatic host_write(input logic [7:0] data);
    bus.hst_wr    = 1'b1;
    bus.hst_wdata = data;
    tick();
    bus.hst_wr    = 1'b0;
  endtask

  task automatic do_rewind();
    bus.eng_rewind = 1'b1;
    tick();
    bus.eng_rewind = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    reset_n         = 1'b0;
    bus.clken       = 1'b1;
    bus.hst_addr_ld = 1'b0;
    bus.hst_addr_in = 4'd0;
    bus.hst_wr      = 1'b0;
    bus.hst_wdata   = 8'h00;
    bus.eng_rewind  = 1'b0;
    bus.eng_running = 1'b0;
    bus.maddr_inc   = 1'b0;

    // Engine emulation STROBE, STROBE, STOP with clken high.
    vecs[0] = '{1'b0, 8'h02, 4'd0};
    vecs[1] = '{1'b1, 8'h02, 4'd1};
    vecs[2] = '{1'b0, 8'h02, 4'd1};
    vecs[3] = '{1'b1, 8'h3F, 4'd2};
    vecs[4] = '{1'b0, 8'h3F, 4'd2};

    // Reset state
    repeat (3) tick();
    check("rst_mdat",     32'(bus.mdat),     32'h3F);
    check("rst_ready",    32'(bus.ready),    32'h0);
    check("rst_eng_addr", 32'(bus.eng_addr), 32'h0);
    check("rst_hst_ptr",  32'(bus.hst_ptr),  32'h0);
    check("rst_wrapped",  32'(bus.wrapped),  32'h0);
    check("rst_underrun", 32'(bus.underrun), 32'h0);
    reset_n = 1'b1;
    tick();

    // Reset mid-fill: underrun during RW0, then reset while in RW1
    bus.eng_rewind = 1'b1;
    tick();
    bus.eng_rewind = 1'b0;
    bus.maddr_inc  = 1'b1;
    tick();
    bus.maddr_inc  = 1'b0;
    check("midfill_underrun_set", 32'(bus.underrun), 32'h1);
    reset_n = 1'b0;
    #1;
    check("midfill_rst_mdat",     32'(bus.mdat),     32'h3F);
    check("midfill_rst_ready",    32'(bus.ready),    32'h0);
    check("midfill_rst_underrun", 32'(bus.underrun), 32'h0);
    tick();
    reset_n = 1'b1;
    repeat (4) tick();
    check("midfill_stays_idle", 32'(bus.ready), 32'h0);
    check("midfill_idle_mdat",  32'(bus.mdat),  32'h3F);

    // Host load of 02,02,3F at 0 and rewind latency
    host_load(4'd0);
    host_write(8'h02);
    host_write(8'h02);
    host_write(8'h3F);
    check("load_hst_ptr", 32'(bus.hst_ptr), 32'h3);
    bus.eng_rewind = 1'b1;
    tick();
    bus.eng_rewind = 1'b0;
    tick();
    check("rw_r1_ready", 32'(bus.ready), 32'h0);
    tick();
    check("rw_r2_ready", 32'(bus.ready), 32'h0);
    check("rw_r2_mdat",  32'(bus.mdat),  32'h02);
    tick();
    check("rw_r3_ready",    32'(bus.ready),    32'h1);
    check("rw_r3_mdat",     32'(bus.mdat),     32'h02);
    check("rw_r3_eng_addr", 32'(bus.eng_addr), 32'h0);

    // Table-driven engine sequence
    for (int i = 0; i < 5; i++) begin
      bus.maddr_inc = vecs[i].inc;
      exp_q.push_back(vecs[i].mdat);
      #1;
      check("seq_mdat", 32'(bus.mdat), 32'(exp_q.pop_front()));
      tick();
      check("seq_addr", 32'(bus.eng_addr), 32'(vecs[i].addr));
    end
    bus.maddr_inc = 1'b0;
    check("seq_underrun", 32'(bus.underrun), 32'h0);

    // Sparse clken (1 in 4) with maddr_inc held for 4 clocks
    host_load(4'd0);
    for (int i = 0; i < 8; i++) host_write(8'h10 + 8'(i));
    do_rewind();
    check("sparse_start_addr", 32'(bus.eng_addr), 32'h0);
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 4; c++) begin
        bus.clken     = (c == 3);
        bus.maddr_inc = 1'b1;
        exp_q.push_back(8'h11 + 8'(p));
        #1;
        check("sparse_mdat_nxt", 32'(bus.mdat), 32'(exp_q.pop_front()));
        check("sparse_addr_pre", 32'(bus.eng_addr), 32'(p));
        tick();
      end
      bus.maddr_inc = 1'b0;
      bus.clken     = 1'b0;
      check("sparse_addr_post", 32'(bus.eng_addr), 32'(p + 1));
      repeat (3) tick();
      check("sparse_mdat_cur", 32'(bus.mdat), 32'(8'h11 + 8'(p)));
    end
    bus.clken = 1'b1;

    // Wrap: 16 bytes of 02, 16 advances
    host_load(4'd0);
    for (int i = 0; i < 16; i++) host_write(8'h02);
    check("wrap_hst_ptr_mod", 32'(bus.hst_ptr), 32'h0);
    do_rewind();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        check("wrap_pre_addr",    32'(bus.eng_addr), 32'hF);
        check("wrap_pre_wrapped", 32'(bus.wrapped),  32'h0);
      end
      bus.maddr_inc = 1'b1;
      tick();
      bus.maddr_inc = 1'b0;
      tick();
    end
    check("wrap_addr",    32'(bus.eng_addr), 32'h0);
    check("wrap_wrapped", 32'(bus.wrapped),  32'h1);

    // Guard: rewind while running is ignored
    bus.eng_running = 1'b1;
    bus.eng_rewind  = 1'b1;
    tick();
    bus.eng_rewind  = 1'b0;
    bus.eng_running = 1'b0;
    tick();
    check("guard_run_ready",   32'(bus.ready),   32'h1);
    check("guard_run_wrapped", 32'(bus.wrapped), 32'h1);

    // Rewind clears wrapped; maddr_inc during RW1 sets underrun
    bus.eng_rewind = 1'b1;
    tick();
    bus.eng_rewind = 1'b0;
    check("rewind_clears_wrapped", 32'(bus.wrapped), 32'h0);
    tick();
    bus.maddr_inc = 1'b1;
    tick();
    bus.maddr_inc = 1'b0;
    check("rw1_underrun", 32'(bus.underrun), 32'h1);
    check("rw1_no_move",  32'(bus.eng_addr), 32'h0);
    tick();
    check("rw1_ready_after", 32'(bus.ready), 32'h1);

    // Guard: load + write in one cycle loads pointer and writes nothing
    bus.hst_addr_ld = 1'b1;
    bus.hst_addr_in = 4'd1;
    bus.hst_wr      = 1'b1;
    bus.hst_wdata   = 8'hAA;
    tick();
    bus.hst_addr_ld = 1'b0;
    bus.hst_wr      = 1'b0;
    check("ldwr_hst_ptr", 32'(bus.hst_ptr), 32'h1);
    do_rewind();
    check("rewind_clears_underrun", 32'(bus.underrun), 32'h0);
    exp_q.push_back(8'h02);
    check("ldwr_ram0", 32'(bus.mdat), 32'(exp_q.pop_front()));
    bus.maddr_inc = 1'b1;
    exp_q.push_back(8'h02);
    #1;
    check("ldwr_ram1", 32'(bus.mdat), 32'(exp_q.pop_front()));
    bus.maddr_inc = 1'b0;

    // Host write to eng_addr+2 in the cycle it is read returns the old byte
    host_load(4'd2);
    bus.maddr_inc = 1'b1;
    bus.hst_wr    = 1'b1;
    bus.hst_wdata = 8'h55;
    tick();
    bus.maddr_inc = 1'b0;
    bus.hst_wr    = 1'b0;
    check("collide_hst_ptr", 32'(bus.hst_ptr), 32'h3);
    tick();
    bus.maddr_inc = 1'b1;
    #1;
    check("collide_old_byte", 32'(bus.mdat), 32'h02);
    bus.maddr_inc = 1'b0;
    do_rewind();
    bus.maddr_inc = 1'b1;
    tick();
    bus.maddr_inc = 1'b0;
    tick();
    bus.maddr_inc = 1'b1;
    #1;
    check("collide_new_byte", 32'(bus.mdat), 32'h55);
    bus.maddr_inc = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
